mac_operand_loader: RTL and testbench
=====================================

// Module: mac_operand_loader
// PURPOSE
//  Upstream feeder for the registered multiply-add stage (DATA_OUT <= A*B+C, 2-clk latency).
//  Takes a byte stream on a valid/ready interface, assembles bytes into (A,B,C) operand triplets,
//  queues them in a small FIFO and presents one triplet per cycle to the MAC.
//  res_valid marks the cycles in which the MAC's DATA_OUT carries a result of a real triplet.
// PARAMETERS
//  WIDTH        8  operand / byte width (A, B, C, din)
//  DEPTH        4  triplet FIFO entries; power of 2, >= 2
//  MAC_LATENCY  2  clocks from A/B/C applied to matching DATA_OUT of the MAC stage
// PORTS
//  clk        in   1                  system clock, all logic on posedge
//  reset      in   1                  asynchronous, active-high; clears all state
//  din        in   WIDTH              input byte, order A,B,C within a triplet
//  din_valid  in   1                  din is valid this cycle
//  din_ready  out  1                  loader accepts din this cycle
//  sync       in   1                  force phase to A (triplet realignment)
//  A          out  WIDTH              FIFO head operand A (0 when op_valid=0)
//  B          out  WIDTH              FIFO head operand B (0 when op_valid=0)
//  C          out  WIDTH              FIFO head operand C (0 when op_valid=0)
//  op_valid   out  1                  FIFO not empty; A/B/C hold a real triplet
//  op_ready   in   1                  MAC consumes head this cycle (tie 1 for free-running MAC)
//  res_valid  out  1                  op fire delayed MAC_LATENCY clocks
//  count      out  $clog2(DEPTH)+1    triplets stored
// BEHAVIOUR
//  - Reset (async assert, sync release): phase=PH_A, FIFO empty, count=0, A/B/C=0, op_valid=0,
//    res_valid pipe all 0, din_ready=1, partial triplet regs=0. Mid-operation reset drops all data.
//  - Byte accept: acc = din_valid & din_ready. Phase PH_A: latch din to a_reg, ->PH_B.
//    PH_B: latch b_reg, ->PH_C. PH_C: push {a_reg,b_reg,din} into FIFO, ->PH_A (wrap).
//  - din_ready = !(phase==PH_C && full). No combinational path from op_ready to din_ready;
//    a full FIFO blocks the C byte even if a pop happens in the same cycle.
//  - sync=1: the current cycle is treated as phase PH_A. If acc, din is latched as A, ->PH_B;
//    otherwise phase->PH_A. Any partial triplet is discarded; a triplet already pushed is kept.
//  - Pop: fire = op_valid & op_ready; head advances next clock. Push and pop in the same cycle
//    (not full): count unchanged, both take effect. Pop when empty: ignored.
//  - A/B/C/op_valid driven directly from FIFO storage/pointers (no extra register stage);
//    a pushed triplet is visible on A/B/C the clock after the C byte is accepted.
//  - res_valid: shift register of fire, MAC_LATENCY deep; res_valid(t) = fire(t-MAC_LATENCY).
//  - Pointers $clog2(DEPTH) bits, wrap modulo DEPTH; full = count==DEPTH, empty = count==0.
//  - No arithmetic on data; widths pass through unchanged.
// STRUCTURE
//  - Package mac_pkg: typedef enum logic [1:0] {PH_A,PH_B,PH_C} phase_t;
//    typedef struct packed {a,b,c [WIDTH-1:0]} triplet_t; localparam MAC_LATENCY_DEF = 2.
//  - Sub-module triplet_fifo (DEPTH x triplet_t: push/pop/full/empty/count, async reset).
//  - Top: phase FSM + a_reg/b_reg, FIFO instance, res_valid shift register.
// TESTING
//  1 Single triplet: bytes 3,4,5 with op_ready=1 -> A=3,B=4,C=5, op_valid for 1 clk, res_valid
//    2 clks after fire; the MAC's DATA_OUT = 17 (8'h11) in that cycle.
//  2 Fill: op_ready=0, send 5 triplets -> count=4, din_ready=0 at 3rd byte of 5th triplet;
//    raise op_ready -> that C byte accepted the cycle after the first pop, order preserved.
//  3 Sync: send 7,8 then sync with din=1, then 2,3 -> one triplet (1,2,3); 7,8 discarded.
//  4 Overflow of result: 200,2,100 -> A*B+C mod 256 = 244 (8'hF4); res_valid aligned.
//  5 Simultaneous push/pop at count=2 -> count stays 2 for back-to-back streaming triplets.
//  6 Reset after A,B and with 2 queued -> op_valid=0, count=0, res_valid=0 at once; next bytes
//    9,9,9 -> triplet (9,9,9).

Source files
------------

// File: rtl/mac_operand_loader_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mac_pkg : shared types and defaults for the MAC operand loader             |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package mac_pkg;

  localparam int OP_WIDTH_DEF    = 8;
  localparam int FIFO_DEPTH_DEF  = 4;
  localparam int MAC_LATENCY_DEF = 2;

  typedef enum logic [1:0] {
    PH_A = 2'd0,
    PH_B = 2'd1,
    PH_C = 2'd2
  } phase_t;

  typedef struct packed {
    logic [OP_WIDTH_DEF-1:0] a;
    logic [OP_WIDTH_DEF-1:0] b;
    logic [OP_WIDTH_DEF-1:0] c;
  } triplet_t;

endpackage
`default_nettype wire

// File: rtl/triplet_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | triplet_fifo : DEPTH-entry FIFO of packed operand triplets, async reset    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module triplet_fifo
  import mac_pkg::*;
#(
  parameter int DW    = 3 * OP_WIDTH_DEF,
  parameter int DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic [DW-1:0]            wdata_i,
  input  logic                     pop_i,
  output logic [DW-1:0]            rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;
  logic [AW:0]   count_d;
  logic          push_ok;
  logic          pop_ok;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;
  assign count_o = count_q;
  // Head is forced to zero while empty so the MAC never sees stale data.
  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      count_q <= count_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mac_operand_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mac_operand_loader : byte stream -> (A,B,C) triplets -> FIFO -> MAC stage  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module mac_operand_loader
  import mac_pkg::*;
#(
  parameter int WIDTH       = OP_WIDTH_DEF,
  parameter int DEPTH       = FIFO_DEPTH_DEF,
  parameter int MAC_LATENCY = MAC_LATENCY_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [WIDTH-1:0]       din,
  input  logic                   din_valid,
  output logic                   din_ready,
  input  logic                   sync,
  output logic [WIDTH-1:0]       A,
  output logic [WIDTH-1:0]       B,
  output logic [WIDTH-1:0]       C,
  output logic                   op_valid,
  input  logic                   op_ready,
  output logic                   res_valid,
  output logic [$clog2(DEPTH):0] count
);

  localparam int TW = 3 * WIDTH;

  phase_t                 phase_q;
  phase_t                 cur_phase;
  logic [WIDTH-1:0]       a_q;
  logic [WIDTH-1:0]       b_q;
  logic                   acc;
  logic                   push;
  logic                   fire;
  logic                   full;
  logic                   empty;
  logic [TW-1:0]          head;
  logic [MAC_LATENCY-1:0] res_q;

  // Only the C byte can be stalled; full comes from the stored count, never from op_ready.
  assign din_ready = !((phase_q == PH_C) && full);
  assign acc       = din_valid & din_ready;
  assign cur_phase = sync ? PH_A : phase_q;
  assign push      = acc && (cur_phase == PH_C);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_q <= PH_A;
      a_q     <= '0;
      b_q     <= '0;
    end else if (acc) begin
      case (cur_phase)
        PH_A: begin
          a_q     <= din;
          phase_q <= PH_B;
        end
        PH_B: begin
          b_q     <= din;
          phase_q <= PH_C;
        end
        default: phase_q <= PH_A;
      endcase
    end else if (sync) begin
      phase_q <= PH_A;
    end
  end

  triplet_fifo #(
    .DW    (TW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .wdata_i ({a_q, b_q, din}),
    .pop_i   (fire),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );

  assign op_valid = ~empty;
  assign fire     = op_valid & op_ready;
  assign A        = head[TW-1 -: WIDTH];
  assign B        = head[2*WIDTH-1 -: WIDTH];
  assign C        = head[WIDTH-1:0];

  generate
    if (MAC_LATENCY == 1) begin : g_lat1
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          res_q <= '0;
        end else begin
          res_q <= fire;
        end
      end
    end else begin : g_latn
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          res_q <= '0;
        end else begin
          res_q <= {res_q[MAC_LATENCY-2:0], fire};
        end
      end
    end
  endgenerate

  assign res_valid = res_q[MAC_LATENCY-1];

endmodule
`default_nettype wire

// File: tb/tb_mac_operand_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mac_operand_loader : directed vectors plus multi-cycle corner sequences |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_mac_operand_loader;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] din;
  logic       din_valid;
  logic       din_ready;
  logic       sync;
  logic [7:0] a_o, b_o, c_o;
  logic       op_valid;
  logic       op_ready;
  logic       res_valid;
  logic [2:0] count;

  int n_app  = 0;
  int n_miss = 0;

  // Behavioural registered multiply-add stage fed by the loader.
  logic [7:0] mac_p1, mac_out;
  always @(posedge clk) begin
    mac_p1  <= 8'(a_o * b_o + c_o);
    mac_out <= mac_p1;
  end

  always #5 clk = ~clk;

  mac_operand_loader #(.WIDTH(8), .DEPTH(4), .MAC_LATENCY(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .sync      (sync),
    .A         (a_o),
    .B         (b_o),
    .C         (c_o),
    .op_valid  (op_valid),
    .op_ready  (op_ready),
    .res_valid (res_valid),
    .count     (count)
  );

  typedef struct {
    logic       sync, dv;
    logic [7:0] din;
    logic       ordy;
    logic       e_rdy, e_ov;
    logic [7:0] ea, eb, ec;
    logic [2:0] ecnt;
    logic       erv;
    logic [7:0] emac;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic s, input logic dv, input logic [7:0] d, input logic ordy,
                              input logic rdy, input logic ov, input logic [7:0] ea,
                              input logic [7:0] eb, input logic [7:0] ec, input logic [2:0] cnt,
                              input logic rv, input logic [7:0] emac);
    vec_t v;
    v.sync = s;   v.dv = dv;  v.din = d;  v.ordy = ordy;
    v.e_rdy = rdy; v.e_ov = ov; v.ea = ea; v.eb = eb; v.ec = ec;
    v.ecnt = cnt; v.erv = rv; v.emac = emac;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_app++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic byte_in(input logic [7:0] b, input logic ordy);
    din = b; din_valid = 1'b1; op_ready = ordy; sync = 1'b0;
    #1;
    chk("byte_in din_ready", din_ready, 1'b1);
    cyc();
  endtask

  task automatic idle(input int n);
    din_valid = 1'b0; op_ready = 1'b1; sync = 1'b0;
    for (int i = 0; i < n; i++) cyc();
  endtask

  initial begin
    int head_exp [3];
    reset = 1'b1; din = '0; din_valid = 1'b0; sync = 1'b0; op_ready = 1'b0;
    cyc(); cyc();
    reset = 1'b0;
    #1;
    chk("reset din_ready", din_ready, 1'b1);
    chk("reset op_valid", op_valid, 1'b0);
    chk("reset count", count, 3'd0);
    chk("reset res_valid", res_valid, 1'b0);
    chk("reset A", a_o, 8'd0);
    cyc();

    // Single triplet 3,4,5 -> 17
    tbl.push_back(mk(0,1,  3,1, 1,0,0,0,0,0,0,0));
    tbl.push_back(mk(0,1,  4,1, 1,0,0,0,0,0,0,0));
    tbl.push_back(mk(0,1,  5,1, 1,0,0,0,0,0,0,0));
    tbl.push_back(mk(0,0,  0,1, 1,1,3,4,5,1,0,0));
    tbl.push_back(mk(0,0,  0,1, 1,0,0,0,0,0,0,0));
    tbl.push_back(mk(0,0,  0,1, 1,0,0,0,0,0,1,8'h11));
    tbl.push_back(mk(0,0,  0,1, 1,0,0,0,0,0,0,0));
    // Result wraps: 200*2+100 mod 256 = 244
    tbl.push_back(mk(0,1,200,1, 1,0,0,0,0,0,0,0));
    tbl.push_back(mk(0,1,  2,1, 1,0,0,0,0,0,0,0));
    tbl.push_back(mk(0,1,100,1, 1,0,0,0,0,0,0,0));
    tbl.push_back(mk(0,0,  0,1, 1,1,200,2,100,1,0,0));
    tbl.push_back(mk(0,0,  0,1, 1,0,0,0,0,0,0,0));
    tbl.push_back(mk(0,0,  0,1, 1,0,0,0,0,0,1,8'hF4));
    tbl.push_back(mk(0,0,  0,1, 1,0,0,0,0,0,0,0));
    // Sync realignment: 7,8 discarded, triplet (1,2,3)
    tbl.push_back(mk(0,1,  7,1, 1,0,0,0,0,0,0,0));
    tbl.push_back(mk(0,1,  8,1, 1,0,0,0,0,0,0,0));
    tbl.push_back(mk(1,1,  1,1, 1,0,0,0,0,0,0,0));
    tbl.push_back(mk(0,1,  2,1, 1,0,0,0,0,0,0,0));
    tbl.push_back(mk(0,1,  3,1, 1,0,0,0,0,0,0,0));
    tbl.push_back(mk(0,0,  0,1, 1,1,1,2,3,1,0,0));
    tbl.push_back(mk(0,0,  0,1, 1,0,0,0,0,0,0,0));
    tbl.push_back(mk(0,0,  0,1, 1,0,0,0,0,0,1,8'd5));
    tbl.push_back(mk(0,0,  0,1, 1,0,0,0,0,0,0,0));

    foreach (tbl[i]) begin
      sync = tbl[i].sync; din_valid = tbl[i].dv; din = tbl[i].din; op_ready = tbl[i].ordy;
      #1;
      chk($sformatf("v%0d din_ready", i), din_ready, tbl[i].e_rdy);
      chk($sformatf("v%0d op_valid", i), op_valid, tbl[i].e_ov);
      chk($sformatf("v%0d A", i), a_o, tbl[i].ea);
      chk($sformatf("v%0d B", i), b_o, tbl[i].eb);
      chk($sformatf("v%0d C", i), c_o, tbl[i].ec);
      chk($sformatf("v%0d count", i), count, tbl[i].ecnt);
      chk($sformatf("v%0d res_valid", i), res_valid, tbl[i].erv);
      if (tbl[i].erv) chk($sformatf("v%0d mac", i), mac_out, tbl[i].emac);
      cyc();
    end
    sync = 1'b0;

    // Fill: five triplets with the consumer stalled
    for (int i = 1; i <= 4; i++) begin
      byte_in(8'(10*i+1), 1'b0);
      byte_in(8'(10*i+2), 1'b0);
      byte_in(8'(10*i+3), 1'b0);
    end
    din_valid = 1'b0; #1;
    chk("fill count", count, 3'd4);
    chk("fill head A", a_o, 8'd11);
    byte_in(8'd51, 1'b0);
    byte_in(8'd52, 1'b0);
    din = 8'd53; din_valid = 1'b1; op_ready = 1'b0; #1;
    chk("full blocks C", din_ready, 1'b0);
    cyc();
    chk("full still blocks C", din_ready, 1'b0);
    op_ready = 1'b1; #1;
    chk("blocked during pop", din_ready, 1'b0);
    chk("pop head A", a_o, 8'd11);
    cyc();
    op_ready = 1'b0; #1;
    chk("C ready after pop", din_ready, 1'b1);
    chk("count after pop", count, 3'd3);
    cyc();
    din_valid = 1'b0; #1;
    chk("count refilled", count, 3'd4);
    op_ready = 1'b1;
    for (int i = 2; i <= 5; i++) begin
      #1;
      chk("drain A", a_o, 8'(10*i+1));
      chk("drain B", b_o, 8'(10*i+2));
      chk("drain C", c_o, 8'(10*i+3));
      cyc();
    end
    #1;
    chk("drained op_valid", op_valid, 1'b0);
    chk("drained count", count, 3'd0);
    idle(3);

    // Simultaneous push/pop holding count at 2
    byte_in(8'd61, 0); byte_in(8'd62, 0); byte_in(8'd63, 0);
    byte_in(8'd64, 0); byte_in(8'd65, 0); byte_in(8'd66, 0);
    din_valid = 1'b0; #1;
    chk("pp count start", count, 3'd2);
    head_exp[0] = 61; head_exp[1] = 64; head_exp[2] = 70;
    for (int j = 0; j < 3; j++) begin
      byte_in(8'(70+3*j), 1'b0);
      byte_in(8'(71+3*j), 1'b0);
      din = 8'(72+3*j); din_valid = 1'b1; op_ready = 1'b1; #1;
      chk("pp C ready", din_ready, 1'b1);
      chk("pp head A", a_o, head_exp[j][7:0]);
      cyc();
      din_valid = 1'b0; op_ready = 1'b0; #1;
      chk("pp count held", count, 3'd2);
    end
    op_ready = 1'b1;
    #1; chk("pp tail A0", a_o, 8'd73); chk("pp tail C0", c_o, 8'd75); cyc();
    #1; chk("pp tail A1", a_o, 8'd76); chk("pp tail C1", c_o, 8'd78); cyc();
    idle(3);

    // Mid-operation reset
    byte_in(8'd21, 0); byte_in(8'd22, 0); byte_in(8'd23, 0);
    byte_in(8'd24, 0); byte_in(8'd25, 0); byte_in(8'd26, 0);
    byte_in(8'd27, 0); byte_in(8'd28, 0); byte_in(8'd29, 0);
    din_valid = 1'b0; op_ready = 1'b1; #1;
    cyc();
    op_ready = 1'b0;
    byte_in(8'd1, 1'b0);
    din = 8'd2; din_valid = 1'b1; #1;
    chk("pre-reset res_valid", res_valid, 1'b1);
    chk("pre-reset count", count, 3'd2);
    reset = 1'b1; #1;
    chk("async reset op_valid", op_valid, 1'b0);
    chk("async reset count", count, 3'd0);
    chk("async reset res_valid", res_valid, 1'b0);
    chk("async reset A", a_o, 8'd0);
    cyc();
    din_valid = 1'b0; reset = 1'b0;
    cyc();
    byte_in(8'd9, 0); byte_in(8'd9, 0); byte_in(8'd9, 0);
    din_valid = 1'b0; #1;
    chk("post-reset count", count, 3'd1);
    chk("post-reset op_valid", op_valid, 1'b1);
    chk("post-reset A", a_o, 8'd9);
    chk("post-reset B", b_o, 8'd9);
    chk("post-reset C", c_o, 8'd9);
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_app, n_miss);
    $finish;
  end

endmodule
`default_nettype wire
